scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder; generalises the team's 3-to-8 combinational decoder.
- Adds two features:
  - a valid/ready input handshake with a registered, held output;
  - an autonomous scan mode that walks the one-hot output across all channels with a programmable dwell time.
- Drives channel/row selects in the same datapath as the existing decoders.
- Output-disable is signalled on out_valid instead of using internal tri-states.

Parameters:
- SEL_W, 3, select width; output width OUT_W = 2**SEL_W is derived (localparam), SEL_W range 1..6.
- DWELL_W, 8, width of the dwell-count input and the internal dwell counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  block enable; 0 forces IDLE.
- mode  input  1  0 = decode mode, 1 = scan mode.
- in_valid  input  1  in_sel is valid this cycle.
- in_ready  output  1  block accepts in_sel this cycle (combinational from state/en/mode).
- in_sel  input  SEL_W  channel index to decode.
- dwell  input  DWELL_W  scan mode: each channel is held dwell+1 cycles.
- out  output  OUT_W  registered one-hot select; all zero when out_valid=0.
- out_valid  output  1  out holds a valid one-hot code.
- out_idx  output  SEL_W  binary index of the asserted out bit.
- wrap  output  1  one-cycle pulse when scan wraps from OUT_W-1 to 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, out=0, out_valid=0, out_idx=0, wrap=0, dwell counter=0.
  - Reset mid-scan or mid-decode aborts immediately; there is no resumption.
- All outputs except in_ready are registered. Invariant: out == (out_valid ? 1<<out_idx : 0).
- States: IDLE, DECODE, SCAN. Priority order: rst_n, then en, then mode, then in_valid.
- en=0 (any state):
  - Next cycle: state=IDLE, out=0, out_valid=0, wrap=0.
  - in_ready=0 while en=0.
- IDLE:
  - out=0, out_valid=0.
  - en=1, mode=0: in_ready=1. If in_valid=1, next cycle out=1<<in_sel, out_idx=in_sel, out_valid=1, state=DECODE. Latency is 1 cycle.
  - en=1, mode=1: next cycle state=SCAN, out_idx=0, out=1, out_valid=1, dwell counter loaded with dwell.
- DECODE:
  - in_ready=1.
  - Each accepted in_sel updates out/out_idx on the next cycle.
  - With no accept, the output holds indefinitely.
  - Re-accepting the same index leaves out unchanged; there is no glitch.
  - mode=1: next cycle enters SCAN at index 0, exactly as from IDLE.
- SCAN:
  - in_ready=0; in_valid is ignored.
  - Dwell counter decrements each cycle. When it is 0 and mode=1, en=1:
    - out_idx <= out_idx+1 mod OUT_W;
    - counter reloads from the current dwell input;
    - if the old index was OUT_W-1, wrap=1 for exactly the cycle the new index 0 is presented.
  - dwell=0 advances the index every cycle. dwell=2^DWELL_W-1 holds each channel 2^DWELL_W cycles.
  - A dwell change takes effect only at the next reload.
- mode 1->0 while in SCAN: next cycle state=DECODE, and the current out/out_idx are held. If in_valid=1 in that same cycle, the handshake is not accepted, because in_ready was 0.
- SEL_W=1 degenerates to a 1-to-2 decoder. Scan toggles 01/10, and wrap pulses every second advance.

Test Plan:
- Reset then decode (SEL_W=3): rst_n low mid-operation -> out=0, out_valid=0 at once. Release, en=1, mode=0, in_valid=1, in_sel=5 -> next cycle out=8'b0010_0000, out_idx=5, out_valid=1.
- Handshake hold: after accepting in_sel=2, drop in_valid for 10 cycles -> out stays 8'b0000_0100. Accept in_sel=7 -> out=8'b1000_0000 one cycle later.
- Scan dwell: mode=1, dwell=2 -> out_idx sequence 0,0,0,1,1,1,...,7,7,7,0. wrap is high exactly in the first cycle of the returned index 0, once per 24 cycles.
- Scan dwell=0 -> index advances every cycle, wrap every 8 cycles, in_ready=0 throughout. An in_valid pulse with in_sel=3 has no effect.
- Priority: en=0 while scanning at idx 4 -> next cycle out=0, out_valid=0. en=0 together with in_valid=1 -> not accepted. Then mode 1->0 at idx 6 -> out holds 8'b0100_0000 in DECODE.
- Parameter sweep SEL_W=1 and SEL_W=5: decode all indices exhaustively, checking out==1<<out_idx. Scan full cycle, checking wrap period = OUT_W*(dwell+1).

Source files
------------

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//
// Registered SEL_W-to-2**SEL_W one-hot decoder that drives channel/row selects.
// Two ways of choosing the asserted channel:
//   - decode mode (mode=0): in_sel is taken through a valid/ready handshake.
//     It is presented one cycle later and held until the next accept.
//   - scan mode (mode=1): the one-hot output walks over every channel on its
//     own. Each channel is held for dwell+1 cycles.
// When the output is disabled, out_valid is low and out is forced to zero.
// Tri-states are not used for this.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         block enable; low forces IDLE on the next edge
//   mode       0 = decode, 1 = scan
//   in_valid   in_sel is valid this cycle
//   in_ready   in_sel is accepted this cycle (combinational)
//   in_sel     channel index to decode
//   dwell      scan hold time minus one, sampled at every channel reload
//   out        registered one-hot select, zero when out_valid is low
//   out_valid  out carries a valid one-hot code
//   out_idx    binary index of the asserted out bit
//   wrap       one-cycle pulse with the first cycle of index 0 after a wrap
// -----------------------------------------------------------------------------
module scan_decoder #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(1<<SEL_W)-1:0] out,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      out_idx,
    output logic                  wrap
);

    localparam int OUT_W = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t               state_reg;
    logic [OUT_W-1:0]     out_reg;
    logic                 out_valid_reg;
    logic [SEL_W-1:0]     out_idx_reg;
    logic                 wrap_reg;
    logic [DWELL_W-1:0]   dwell_cnt_reg;

    logic [OUT_W-1:0]     sel_onehot;
    logic                 accept;

    // Plain combinational decode of the incoming index. It is only loaded
    // into out_reg on an accepted handshake.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi = gi + 1) begin : g_dec
            assign sel_onehot[gi] = (in_sel == SEL_W'(gi));
        end
    endgenerate

    // The handshake is closed while scanning and whenever scan is requested.
    // mode outranks in_valid, so no accept can race a scan entry.
    assign in_ready = en && !mode && (state_reg != SCAN);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            wrap_reg      <= 1'b0;
            dwell_cnt_reg <= '0;
        end else if (!en) begin
            state_reg     <= IDLE;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            wrap_reg      <= 1'b0;
            dwell_cnt_reg <= '0;
        end else begin
            // wrap is a single-cycle pulse. It is set only on the advance
            // out of the last channel.
            wrap_reg <= 1'b0;
            case (state_reg)
                IDLE, DECODE: begin
                    if (mode) begin
                        state_reg     <= SCAN;
                        out_reg       <= OUT_W'(1);
                        out_valid_reg <= 1'b1;
                        out_idx_reg   <= '0;
                        dwell_cnt_reg <= dwell;
                    end else if (accept) begin
                        // Re-accepting the current index rewrites identical
                        // values, so the select lines never glitch.
                        state_reg     <= DECODE;
                        out_reg       <= sel_onehot;
                        out_valid_reg <= 1'b1;
                        out_idx_reg   <= in_sel;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        // Leave scan holding the channel currently shown.
                        state_reg <= DECODE;
                    end else if (dwell_cnt_reg == '0) begin
                        // Rotating the one-hot word keeps out consistent
                        // with out_idx + 1 (mod OUT_W) without a second
                        // decoder.
                        out_reg       <= {out_reg[OUT_W-2:0], out_reg[OUT_W-1]};
                        out_idx_reg   <= out_idx_reg + SEL_W'(1);
                        dwell_cnt_reg <= dwell;
                        wrap_reg      <= (out_idx_reg == LAST_IDX);
                    end else begin
                        dwell_cnt_reg <= dwell_cnt_reg - DWELL_W'(1);
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_reg       <= '0;
                    out_valid_reg <= 1'b0;
                    out_idx_reg   <= '0;
                    dwell_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;
    assign wrap      = wrap_reg;

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
//
// Testbench for scan_decoder. It drives three instances (SEL_W = 3, 1, 5) from
// shared stimulus. A behavioural model checks every instance on every cycle.
// The model tracks the channel shown and how many cycles it still has to be
// shown. The bench also runs a table of hand-computed vectors and several
// hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n, en, mode, in_valid;
    logic [4:0]  sel;
    logic [7:0]  dwell;

    logic        rdy3, rdy1, rdy5;
    logic [7:0]  out3;
    logic [1:0]  out1;
    logic [31:0] out5;
    logic        v3, v1, v5;
    logic [2:0]  idx3;
    logic [0:0]  idx1;
    logic [4:0]  idx5;
    logic        w3, w1, w5;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .DWELL_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy3), .in_sel(sel[2:0]), .dwell(dwell), .out(out3),
        .out_valid(v3), .out_idx(idx3), .wrap(w3)
    );

    scan_decoder #(.SEL_W(1), .DWELL_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy1), .in_sel(sel[0:0]), .dwell(dwell), .out(out1),
        .out_valid(v1), .out_idx(idx1), .wrap(w1)
    );

    scan_decoder #(.SEL_W(5), .DWELL_W(8)) u5 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy5), .in_sel(sel), .dwell(dwell), .out(out5),
        .out_valid(v5), .out_idx(idx5), .wrap(w5)
    );

    // Uniform views of the three instances, indexed 0..2.
    logic [31:0] d_out [NI];
    logic [31:0] d_idx [NI];
    logic        d_val [NI];
    logic        d_wrap[NI];
    logic        d_rdy [NI];
    assign d_out[0] = 32'(out3);  assign d_out[1] = 32'(out1);  assign d_out[2] = out5;
    assign d_idx[0] = 32'(idx3);  assign d_idx[1] = 32'(idx1);  assign d_idx[2] = 32'(idx5);
    assign d_val[0] = v3;         assign d_val[1] = v1;         assign d_val[2] = v5;
    assign d_wrap[0] = w3;        assign d_wrap[1] = w1;        assign d_wrap[2] = w5;
    assign d_rdy[0] = rdy3;       assign d_rdy[1] = rdy1;       assign d_rdy[2] = rdy5;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural reference model ----------------
    localparam int S_IDLE = 0, S_DEC = 1, S_SCAN = 2;
    int sw   [NI] = '{3, 1, 5};
    int m_st [NI] = '{default: 0};
    int m_idx[NI] = '{default: 0};
    int m_val[NI] = '{default: 0};
    int m_wrp[NI] = '{default: 0};
    int m_rem[NI] = '{default: 0};   // cycles the current channel is still shown

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset(input int k);
        m_st[k] = S_IDLE; m_idx[k] = 0; m_val[k] = 0; m_wrp[k] = 0; m_rem[k] = 0;
    endtask

    task automatic m_step(input int k);
        int n;
        n = 1 << sw[k];
        m_wrp[k] = 0;
        if (!en) begin
            m_reset(k);
        end else if (m_st[k] == S_SCAN) begin
            if (!mode) begin
                m_st[k] = S_DEC;
            end else begin
                m_rem[k] = m_rem[k] - 1;
                if (m_rem[k] == 0) begin
                    m_wrp[k] = (m_idx[k] == n - 1) ? 1 : 0;
                    m_idx[k] = (m_idx[k] + 1) % n;
                    m_rem[k] = int'(dwell) + 1;
                end
            end
        end else if (mode) begin
            m_st[k] = S_SCAN; m_idx[k] = 0; m_val[k] = 1; m_rem[k] = int'(dwell) + 1;
        end else if (in_valid) begin
            m_st[k] = S_DEC; m_idx[k] = int'(sel) % n; m_val[k] = 1;
        end
    endtask

    // One clock cycle. Inputs were driven at the preceding negedge. in_ready is
    // checked before the edge and the registered outputs just after it.
    task automatic cycle();
        logic [31:0] exp_out;
        #1;
        if (!rst_n) for (int k = 0; k < NI; k++) m_reset(k);
        for (int k = 0; k < NI; k++)
            chk($sformatf("u%0d.in_ready", sw[k]), 32'(d_rdy[k]),
                32'(en && !mode && (m_st[k] != S_SCAN)));
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) m_reset(k);
            else        m_step(k);
        end
        #2;
        for (int k = 0; k < NI; k++) begin
            exp_out = (m_val[k] != 0) ? (32'd1 << m_idx[k]) : 32'd0;
            chk($sformatf("u%0d.out", sw[k]), d_out[k], exp_out);
            chk($sformatf("u%0d.out_valid", sw[k]), 32'(d_val[k]), 32'(m_val[k]));
            chk($sformatf("u%0d.wrap", sw[k]), 32'(d_wrap[k]), 32'(m_wrp[k]));
            if (m_val[k] != 0)
                chk($sformatf("u%0d.out_idx", sw[k]), d_idx[k], 32'(m_idx[k]));
        end
        @(negedge clk);
    endtask

    // ---------------- directed vector table (SEL_W=3 instance) ----------------
    typedef struct {
        logic       en;
        logic       mode;
        logic       iv;
        logic [2:0] sel;
        logic [7:0] dw;
        logic       rdy;
        logic [7:0] out;
        logic       valid;
        logic [2:0] idx;
        logic       wrap;
    } vec_t;

    vec_t tbl[12];

    int first_w [NI];
    int second_w[NI];
    int exp_per [NI];

    initial begin
        //          en    mode  iv    sel   dwell  rdy   out     valid idx   wrap
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 3'd5, 8'd0,  1'b1, 8'h20,  1'b1, 3'd5, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 3'd2, 8'd0,  1'b1, 8'h04,  1'b1, 3'd2, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd7, 8'd0,  1'b1, 8'h04,  1'b1, 3'd2, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 3'd7, 8'd0,  1'b1, 8'h80,  1'b1, 3'd7, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 3'd7, 8'd0,  1'b1, 8'h80,  1'b1, 3'd7, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 3'd3, 8'd0,  1'b0, 8'h00,  1'b0, 3'd0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd3, 8'd0,  1'b1, 8'h00,  1'b0, 3'd0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 3'd0, 8'd0,  1'b1, 8'h01,  1'b1, 3'd0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 3'd6, 8'd0,  1'b0, 8'h01,  1'b1, 3'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 3'd3, 8'd0,  1'b0, 8'h02,  1'b1, 3'd1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 3'd3, 8'd0,  1'b0, 8'h02,  1'b1, 3'd1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 3'd3, 8'd0,  1'b1, 8'h08,  1'b1, 3'd3, 1'b0};

        rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; sel = '0; dwell = '0;
        repeat (2) cycle();
        chk("reset.out", 32'(out3), 32'd0);
        chk("reset.out_valid", 32'(v3), 32'd0);
        chk("reset.out_idx", 32'(idx3), 32'd0);
        chk("reset.wrap", 32'(w3), 32'd0);

        // Async reset in the middle of a decode takes effect without a clock edge.
        rst_n = 1'b1; en = 1'b1; in_valid = 1'b1; sel = 5'd4;
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst.out", 32'(out3), 32'd0);
        chk("async_rst.out_valid", 32'(v3), 32'd0);
        for (int k = 0; k < NI; k++) m_reset(k);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; in_valid = tbl[i].iv;
            sel = {2'b00, tbl[i].sel}; dwell = tbl[i].dw;
            #1;
            chk($sformatf("tbl%0d.in_ready", i), 32'(rdy3), 32'(tbl[i].rdy));
            cycle();
            chk($sformatf("tbl%0d.out", i), 32'(out3), 32'(tbl[i].out));
            chk($sformatf("tbl%0d.out_valid", i), 32'(v3), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d.wrap", i), 32'(w3), 32'(tbl[i].wrap));
            if (tbl[i].valid) chk($sformatf("tbl%0d.out_idx", i), 32'(idx3), 32'(tbl[i].idx));
            $display("vec %0d: en=%0b mode=%0b in_valid=%0b in_sel=%0d -> out=%h valid=%0b idx=%0d",
                     i, tbl[i].en, tbl[i].mode, tbl[i].iv, tbl[i].sel, out3, v3, idx3);
        end

        // Handshake hold: the output stays put while no new index is accepted.
        in_valid = 1'b1; sel = 5'd2; mode = 1'b0; en = 1'b1;
        cycle();
        chk("hold.accept2", 32'(out3), 32'h04);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sel = 5'($urandom);
            cycle();
            chk("hold.idle", 32'(out3), 32'h04);
        end
        in_valid = 1'b1; sel = 5'd7;
        cycle();
        chk("hold.accept7", 32'(out3), 32'h80);
        $display("hold: accepted 2, idled 10 cycles, accepted 7 -> out=%h", out3);

        // Scan with dwell=2: wrap period must be OUT_W*3 for every width.
        in_valid = 1'b0; mode = 1'b1; dwell = 8'd2;
        exp_per = '{24, 6, 96};
        first_w = '{-1, -1, -1};
        second_w = '{-1, -1, -1};
        for (int t = 0; t < 200; t++) begin
            cycle();
            for (int k = 0; k < NI; k++) begin
                if (d_wrap[k] === 1'b1) begin
                    if (first_w[k] < 0) first_w[k] = t;
                    else if (second_w[k] < 0) second_w[k] = t;
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("u%0d.wrap_first", sw[k]), 32'(first_w[k]), 32'(exp_per[k]));
            chk($sformatf("u%0d.wrap_period", sw[k]),
                (second_w[k] < 0) ? 32'hFFFF_FFFF : 32'(second_w[k] - first_w[k]),
                32'(exp_per[k]));
            $display("scan u%0d: wraps at %0d and %0d", sw[k], first_w[k], second_w[k]);
        end

        // Priority: en=0 mid-scan clears at once and blocks the handshake.
        en = 1'b0; in_valid = 1'b1; sel = 5'd3;
        cycle();
        chk("prio.en0_out", 32'(out3), 32'd0);
        chk("prio.en0_valid", 32'(v3), 32'd0);
        en = 1'b1; in_valid = 1'b0; dwell = 8'd0;
        repeat (7) cycle();
        chk("prio.scan_idx6", 32'(idx3), 32'd6);
        mode = 1'b0; in_valid = 1'b1; sel = 5'd3;
        cycle();
        chk("prio.mode_drop_out", 32'(out3), 32'h40);
        chk("prio.mode_drop_idx", 32'(idx3), 32'd6);
        cycle();
        chk("prio.decode_after", 32'(out3), 32'h08);
        $display("priority: en drop, scan to 6, mode drop held -> out=%h", out3);

        // Maximum dwell holds a channel 256 cycles. A dwell change only lands at
        // the next reload.
        in_valid = 1'b0; mode = 1'b1; dwell = 8'd255;
        cycle();
        dwell = 8'd3;
        repeat (255) cycle();
        chk("dwell255.hold", 32'(idx3), 32'd0);
        cycle();
        chk("dwell255.advance", 32'(idx3), 32'd1);
        repeat (3) cycle();
        chk("dwell3.hold", 32'(idx3), 32'd1);
        cycle();
        chk("dwell3.advance", 32'(idx3), 32'd2);
        $display("dwell: 255 then 3 -> idx=%0d", idx3);

        // Exhaustive decode across all widths.
        mode = 1'b0; in_valid = 1'b1;
        cycle();
        for (int s = 0; s < 32; s++) begin
            sel = 5'(s);
            cycle();
            chk("sweep.out5", out5, 32'd1 << s);
            chk("sweep.out3", 32'(out3), 32'd1 << (s % 8));
            chk("sweep.out1", 32'(out1), 32'd1 << (s % 2));
            $display("sweep: in_sel=%0d -> u5=%h u3=%h u1=%h", s, out5, out3, out1);
        end

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            rst_n    = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            en       = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            in_valid = 1'($urandom);
            sel      = 5'($urandom);
            dwell    = 8'($urandom_range(0, 5));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
